// File: rtl/serial_addsub_if.sv
// serial_addsub_if: request/response bundle for the bit-serial adder/subtractor.
// master drives the operation request, slave returns status and results.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carryout;
  logic             overflow;
  logic             zero;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, carryout, overflow, zero
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, carryout, overflow, zero
  );
endinterface

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial two's-complement adder/subtractor, one bit per clock.
// IDLE -> SHIFT (WIDTH cycles) -> DONE (1 cycle) -> IDLE.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  serial_addsub_if.slave io
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             c_q, c_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic sum;
  logic cout;
  logic last;
  logic accept;

  // One full-adder slice on the operand LSBs
  always_comb begin
    sum  = a_q[0] ^ b_q[0] ^ c_q;
    cout = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));
  end

  assign last   = (cnt_q == CW'(WIDTH - 1));
  assign accept = (state_q == IDLE) && io.start;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (state_q == IDLE):  if (io.start) state_d = SHIFT;
      (state_q == SHIFT): if (last)     state_d = DONE;
      (state_q == DONE):  state_d = IDLE;
      default:            state_d = IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    io.busy = (state_q == SHIFT);
    io.done = (state_q == DONE);
  end

  // Datapath next state: load on accept, shift one bit per SHIFT cycle
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    res_d = res_q;
    c_d   = c_q;
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    if (accept) begin
      a_d   = io.a;
      b_d   = io.sub ? ~io.b : io.b;
      c_d   = io.sub;
      ovf_d = 1'b0;
      cnt_d = '0;
    end else if (state_q == SHIFT) begin
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      res_d = {sum, res_q[WIDTH-1:1]};
      c_d   = cout;
      cnt_d = cnt_q + CW'(1);
      // Carry into the MSB slice vs carry out of it
      if (last) ovf_d = c_q ^ cout;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      c_q   <= 1'b0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      res_q <= res_d;
      c_q   <= c_d;
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
    end
  end

  // Result outputs straight from the registers
  always_comb begin
    io.result   = res_q;
    io.carryout = c_q;
    io.overflow = ovf_q;
    io.zero     = ~|res_q;
  end

endmodule
